// File: rtl/bmm_pkg.sv
// Shared fetch-stage definitions: return-address-stack sizing and the
// checkpoint record the backend stores per predicted branch.
package bmm_pkg;

    localparam int unsigned RAS_DEPTH  = 8;
    localparam int unsigned RAS_PTR_W  = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W  = $clog2(RAS_DEPTH + 1);
    localparam int unsigned ILEN_BYTES = 4;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] tos_ptr;
        logic [RAS_CNT_W-1:0] count;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ctrl_chk.sv
// Simulation checks for ras_ctrl: a restored checkpoint must never carry a
// count larger than the stack depth (the controller clamps it regardless).
module ras_ctrl_chk #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             flush_i,
    input logic             restore_i,
    input logic [CNT_W-1:0] restore_count_i
);

    restore_count_legal: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (restore_i && !flush_i) |-> (32'(restore_count_i) <= DEPTH)
    ) else $error("ras_ctrl: restored count %0d exceeds depth %0d", restore_count_i, DEPTH);

endmodule

// File: rtl/ras_mem.sv
// Return-address-stack storage: register array, one synchronous write
// port and one asynchronous read port. Contents are intentionally not reset.
module ras_mem #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_r [DEPTH];

    // Entry write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: pushes link addresses on calls, predicts
// and pops return targets, and exposes/accepts {tos_ptr, count} checkpoints.
module ras_ctrl
    import bmm_pkg::*;
#(
    parameter int unsigned DEPTH      = RAS_DEPTH,
    parameter int unsigned ILEN_BYTES = bmm_pkg::ILEN_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_vld_i,
    input  logic [31:0] pc_i,
    input  logic        call_i,
    input  logic        return_i,
    output logic        pred_vld_o,
    output logic [31:0] pred_target_o,
    output ras_ckpt_t   ckpt_o,
    input  logic        restore_i,
    input  ras_ckpt_t   restore_ckpt_i,
    input  logic        flush_i,
    output logic        overflow_o,
    output logic        underflow_o
);

    // DEPTH must match RAS_DEPTH so the checkpoint fields line up with the pointers.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [PTR_W-1:0] next_ptr_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic             we_s;
    logic [PTR_W-1:0] waddr_s;
    logic [31:0]      link_s;
    logic [31:0]      tos_data_s;
    logic             overflow_s;
    logic             underflow_s;
    logic             hint_en_s;

    assign link_s    = pc_i + 32'(ILEN_BYTES);
    assign hint_en_s = fetch_vld_i && !flush_i && !restore_i;

    ras_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (link_s),
        .raddr_i (ptr_r),
        .rdata_o (tos_data_s)
    );

    // Same-cycle prediction from the current TOS; zeroed when not valid
    always_comb begin
        pred_vld_o    = 1'b0;
        pred_target_o = 32'd0;
        if (hint_en_s && return_i && (cnt_r != {CNT_W{1'b0}})) begin
            pred_vld_o    = 1'b1;
            pred_target_o = tos_data_s;
        end else begin
            pred_vld_o    = 1'b0;
            pred_target_o = 32'd0;
        end
    end

    // Next pointer/count, entry write and pulse generation
    always_comb begin
        next_ptr_s  = ptr_r;
        next_cnt_s  = cnt_r;
        we_s        = 1'b0;
        waddr_s     = ptr_r;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        if (flush_i) begin
            next_ptr_s = {PTR_W{1'b0}};
            next_cnt_s = {CNT_W{1'b0}};
        end else if (restore_i) begin
            next_ptr_s = restore_ckpt_i.tos_ptr;
            if (restore_ckpt_i.count > CNT_FULL) begin
                next_cnt_s = CNT_FULL;
            end else begin
                next_cnt_s = restore_ckpt_i.count;
            end
        end else if (fetch_vld_i) begin
            case ({call_i, return_i})
                2'b10: begin
                    next_ptr_s = ptr_r + PTR_ONE;
                    waddr_s    = ptr_r + PTR_ONE;
                    we_s       = 1'b1;
                    if (cnt_r == CNT_FULL) begin
                        overflow_s = 1'b1;
                    end else begin
                        next_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        next_ptr_s = ptr_r - PTR_ONE;
                        next_cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        underflow_s = 1'b1;
                    end
                end
                2'b11: begin
                    // Coroutine swap: replace TOS in place; on empty stack it degenerates to a push
                    we_s = 1'b1;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        waddr_s = ptr_r;
                    end else begin
                        next_ptr_s  = ptr_r + PTR_ONE;
                        waddr_s     = ptr_r + PTR_ONE;
                        next_cnt_s  = CNT_ONE;
                        underflow_s = 1'b1;
                    end
                end
                default: begin
                    next_ptr_s = ptr_r;
                    next_cnt_s = cnt_r;
                end
            endcase
        end else begin
            next_ptr_s = ptr_r;
            next_cnt_s = cnt_r;
        end
    end

    // Pointer/count state and registered event pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r       <= {PTR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            ptr_r       <= next_ptr_s;
            cnt_r       <= next_cnt_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    assign ckpt_o      = {ptr_r, cnt_r};
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

    ras_ctrl_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .restore_i       (restore_i),
        .restore_count_i (restore_ckpt_i.count)
    );

endmodule
